// File: rtl/coeff_stream_bank_if.sv
// rtl/coeff_stream_bank_if.sv - coefficient stream handshake bundle
// Purpose: carries one coefficient beat from the bank (master) to the MAC stage (slave).
// Ports (signals):
//   out_valid  master->slave  beat present
//   out_ready  slave->master  consumer accepts the beat
//   out_data   master->slave  signed coefficient
//   out_index  master->slave  slot number of out_data
//   out_last   master->slave  beat is slot DEPTH-1
interface coeff_stream_bank_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 21
);
  localparam int AW = $clog2(DEPTH);

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [AW-1:0]           out_index;
  logic                    out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/coeff_stream_bank.sv
// rtl/coeff_stream_bank.sv - coefficient store and in-order stream sequencer
// Purpose: holds DEPTH signed coefficients (slot DEPTH-1 is the offset) and, on a
//   start pulse, streams them in index order over a valid/ready handshake.
// Optional feature: define COEFF_STREAM_DOUBLE_BUFFER_EN to add a shadow bank that
//   receives all writes and is published to the active bank by commit.
// Ports:
//   CLK            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   wr_en/wr_addr/wr_data  in  coefficient write port (out-of-range address ignored)
//   commit         in   publish shadow bank (double-buffer build only)
//   commit_pending out  commit requested during a pass, applied at its last beat
//   start          in   begin one pass (ignored while busy)
//   busy           out  a pass is in progress
//   strm           master side of the coefficient stream interface
// The interface instance must use the same WIDTH and DEPTH as this module.
module coeff_stream_bank #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 21,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    commit,
  output logic                    commit_pending,
  input  logic                    start,
  output logic                    busy,
  coeff_stream_bank_if.master     strm
);

  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;

  logic signed [WIDTH-1:0] active_bank [DEPTH];
  // Active bank as it will be after this edge; beat loads read this so a write or
  // commit landing on the same edge is seen immediately.
  logic signed [WIDTH-1:0] active_nxt  [DEPTH];
  logic                    wr_hit;
  logic                    last_xfer;

  assign wr_hit    = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign last_xfer = (state == STREAM) && strm.out_ready && strm.out_last;
  assign busy      = (state == STREAM);

`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
  logic signed [WIDTH-1:0] shadow_bank [DEPTH];
  logic signed [WIDTH-1:0] shadow_nxt  [DEPTH];
  logic                    do_copy;

  // Copy in IDLE right away; during a pass defer to the last-beat edge so a pass
  // never mixes two coefficient sets.
  assign do_copy = ((state == IDLE) && commit) ||
                   (last_xfer && (commit_pending || commit));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shadow_nxt[i] = shadow_bank[i];
      if (wr_hit && (wr_addr == AW'(i))) shadow_nxt[i] = wr_data;
      active_nxt[i] = do_copy ? shadow_nxt[i] : active_bank[i];
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        shadow_bank[i] <= '0;
        active_bank[i] <= '0;
      end else begin
        shadow_bank[i] <= shadow_nxt[i];
        active_bank[i] <= active_nxt[i];
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      active_nxt[i] = active_bank[i];
      if (wr_hit && (wr_addr == AW'(i))) active_nxt[i] = wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) active_bank[i] <= '0;
      else       active_bank[i] <= active_nxt[i];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= IDLE;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_index <= '0;
      strm.out_last  <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= STREAM;
            strm.out_valid <= 1'b1;
            strm.out_index <= '0;
            strm.out_data  <= active_nxt[0];
            strm.out_last  <= (LAST_IDX == '0);
          end
        end
        STREAM: begin
          if (strm.out_ready) begin
            if (strm.out_last) begin
              // data and index hold their final values after the pass
              state          <= IDLE;
              strm.out_valid <= 1'b0;
              strm.out_last  <= 1'b0;
            end else begin
              strm.out_index <= strm.out_index + 1'b1;
              strm.out_data  <= active_nxt[strm.out_index + 1'b1];
              strm.out_last  <= ((strm.out_index + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase

`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
      if (state == STREAM) begin
        if (last_xfer)   commit_pending <= 1'b0;
        else if (commit) commit_pending <= 1'b1;
      end
`else
      commit_pending <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_coeff_stream_bank.sv
// tb/tb_coeff_stream_bank.sv - directed self-checking bench for coeff_stream_bank
module tb_coeff_stream_bank;
  localparam int WIDTH = 16;
  localparam int DEPTH = 21;
  localparam int AW    = $clog2(DEPTH);

  localparam int ACT_NONE  = 0;
  localparam int ACT_START = 1;
  localparam int ACT_WRC   = 2;

  logic                    CLK;
  logic                    reset;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [WIDTH-1:0] wr_data;
  logic                    commit;
  logic                    commit_pending;
  logic                    start;
  logic                    busy;

  coeff_stream_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) strm ();

  coeff_stream_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .start          (start),
    .busy           (busy),
    .strm           (strm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int exp_active [DEPTH];
  int exp_shadow [DEPTH];
  int exp_pending = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_write(input int addr, input int data);
    if (addr < DEPTH) begin
`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
      exp_shadow[addr] = data;
`else
      exp_active[addr] = data;
`endif
    end
  endtask

  task automatic write_coeff(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = WIDTH'(data);
    tick();
    wr_en   = 1'b0;
    model_write(addr, data);
  endtask

  task automatic commit_idle();
    commit = 1'b1;
    tick();
    commit = 1'b0;
`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
    for (int i = 0; i < DEPTH; i++) exp_active[i] = exp_shadow[i];
`endif
  endtask

  // One full pass with out_ready high, optionally stalling 3 cycles at stall_idx
  // and applying an action while beat act_idx is presented.
  task automatic run_pass(input string tag, input int stall_idx, input int act_idx,
                          input int act_kind, input int act_addr, input int act_data);
    int last_data;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, "_valid"}, strm.out_valid, 1);
      check({tag, "_index"}, strm.out_index, i);
      check({tag, "_data"},  strm.out_data, exp_active[i]);
      check({tag, "_last"},  strm.out_last, (i == DEPTH-1) ? 1 : 0);
      check({tag, "_busy"},  busy, 1);
      check({tag, "_pend"},  commit_pending, exp_pending);
      last_data = exp_active[i];
      if (i == stall_idx) begin
        strm.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check({tag, "_stall_valid"}, strm.out_valid, 1);
          check({tag, "_stall_index"}, strm.out_index, i);
          check({tag, "_stall_data"},  strm.out_data, exp_active[i]);
        end
        strm.out_ready = 1'b1;
      end
      if (i == act_idx && act_kind == ACT_START) start = 1'b1;
      if (i == act_idx && act_kind == ACT_WRC) begin
        wr_en   = 1'b1;
        wr_addr = AW'(act_addr);
        wr_data = WIDTH'(act_data);
        commit  = 1'b1;
      end
      tick();
      start  = 1'b0;
      wr_en  = 1'b0;
      commit = 1'b0;
      if (i == act_idx && act_kind == ACT_WRC) begin
        model_write(act_addr, act_data);
`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
        exp_pending = 1;
`endif
      end
`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
      if (i == DEPTH-1 && exp_pending == 1) begin
        for (int k = 0; k < DEPTH; k++) exp_active[k] = exp_shadow[k];
        exp_pending = 0;
      end
`endif
    end
    check({tag, "_end_busy"},  busy, 0);
    check({tag, "_end_valid"}, strm.out_valid, 0);
    check({tag, "_end_last"},  strm.out_last, 0);
    check({tag, "_end_index"}, strm.out_index, DEPTH-1);
    check({tag, "_end_data"},  strm.out_data, last_data);
    check({tag, "_end_pend"},  commit_pending, 0);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit = 1'b0;
    start = 1'b0;
    strm.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_active[i] = 0;
      exp_shadow[i] = 0;
    end
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid", strm.out_valid, 0);
    check("rst_data",  strm.out_data, 0);
    check("rst_index", strm.out_index, 0);
    check("rst_last",  strm.out_last, 0);
    check("rst_busy",  busy, 0);
    check("rst_pend",  commit_pending, 0);

    // slot i = i*3-10 : -10, -7, ..., 50
    for (int i = 0; i < DEPTH; i++) write_coeff(i, i*3 - 10);
    commit_idle();
    check("commit_idle_pend", commit_pending, 0);
    check("model_slot0",  exp_active[0], -10);
    check("model_slot20", exp_active[20], 50);

    run_pass("pass1", -1, -1, ACT_NONE, 0, 0);
    run_pass("bp", 5, -1, ACT_NONE, 0, 0);

    // out-of-range write and a start while busy: both must leave no trace
    write_coeff(25, 16'h1234);
    check("oor_busy", busy, 0);
    run_pass("edge", -1, 2, ACT_START, 0, 0);
    tick();
    check("edge_no_restart", busy, 0);

`ifdef COEFF_STREAM_DOUBLE_BUFFER_EN
    run_pass("dbw", -1, 3, ACT_WRC, 10, 32767);
    check("db_new10_model", exp_active[10], 32767);
    run_pass("dbnew", -1, -1, ACT_NONE, 0, 0);
`else
    run_pass("live", -1, 4, ACT_WRC, 15, -1);
    check("live_slot15_model", exp_active[15], -1);
    run_pass("live2", -1, -1, ACT_NONE, 0, 0);
`endif

    // reset while index 8 is presented
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_index", strm.out_index, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", strm.out_valid, 0);
    check("mid_rst_data",  strm.out_data, 0);
    check("mid_rst_index", strm.out_index, 0);
    check("mid_rst_last",  strm.out_last, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_pend",  commit_pending, 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_active[i] = 0;
      exp_shadow[i] = 0;
    end
    exp_pending = 0;
    run_pass("zero", -1, -1, ACT_NONE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
